// File: rtl/reg_file_pkg.sv
// Shared types, defaults and parity helper for the 2R1W register file.
// Optional entry parity is enabled with REG_FILE_PARITY_EN.
package reg_file_pkg;

    typedef enum logic {IDLE, CLEAR} rfState_e;

    localparam int defWidth    = 16;
    localparam int defDepth    = 8;
    localparam int parMaxWidth = 256;

`ifdef REG_FILE_PARITY_EN
    localparam int parBits = 1;
`else
    localparam int parBits = 0;
`endif

    // Zero-extension leaves the XOR reduction unchanged.
    function automatic logic evenPar(input logic [parMaxWidth-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, write-first bypass, output regs.
// Parity checking of the stored entry is added with REG_FILE_PARITY_EN.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH = defWidth,
    parameter int DEPTH = defDepth,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Busy,
    input  logic                     RdEn,
    input  logic [ADDR-1:0]          RdAddr,
    input  logic                     WrEn,
    input  logic [ADDR-1:0]          WrAddr,
    input  logic [WIDTH-1:0]         WrData,
    input  logic [WIDTH+parBits-1:0] Mem [DEPTH],
    output logic [WIDTH-1:0]         RdData,
    output logic                     RdValid
`ifdef REG_FILE_PARITY_EN
    ,
    output logic                     RdErr
`endif
);

    logic                     accept;
    logic                     inRange;
    logic                     hit;
    logic [WIDTH+parBits-1:0] entry;
    logic [WIDTH-1:0]         dataNext;

    assign accept  = RdEn && !Busy;
    assign inRange = 32'(RdAddr) < DEPTH;
    assign hit     = WrEn && (WrAddr == RdAddr);
    assign entry   = Mem[RdAddr];

    // Out-of-range wins over bypass: such a write is dropped anyway.
    always_comb begin
        dataNext = entry[WIDTH-1:0];
        if (!inRange) begin
            dataNext = '0;
        end else if (hit) begin
            dataNext = WrData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RdData  <= '0;
            RdValid <= 1'b0;
        end else begin
            RdValid <= accept;
            if (accept) begin
                RdData <= dataNext;
            end
        end
    end

`ifdef REG_FILE_PARITY_EN
    logic errNext;

    assign errNext = inRange && !hit &&
        (evenPar(parMaxWidth'(entry[WIDTH-1:0])) != entry[WIDTH]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RdErr <= 1'b0;
        end else begin
            RdErr <= accept && errNext;
        end
    end
`endif

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised 2-read/1-write register file with hardware clear sequencer.
// Define REG_FILE_PARITY_EN to add per-entry parity, ParInj and RdErr0/1.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int WIDTH = defWidth,
    parameter int DEPTH = defDepth,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WrEn,
    input  logic [ADDR-1:0]  WrAddr,
    input  logic [WIDTH-1:0] WrData,
    input  logic             RdEn0,
    input  logic [ADDR-1:0]  RdAddr0,
    output logic [WIDTH-1:0] RdData0,
    output logic             RdValid0,
    input  logic             RdEn1,
    input  logic [ADDR-1:0]  RdAddr1,
    output logic [WIDTH-1:0] RdData1,
    output logic             RdValid1,
    input  logic             ClrReq,
    output logic             Busy
`ifdef REG_FILE_PARITY_EN
    ,
    input  logic             ParInj,
    output logic             RdErr0,
    output logic             RdErr1
`endif
);

    localparam int EW = WIDTH + parBits;

    rfState_e        state;
    rfState_e        stateNext;
    logic [ADDR-1:0] cnt;
    logic [ADDR-1:0] cntNext;
    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   wrEntry;
    logic            wrOk;

    assign Busy = (state == CLEAR);
    assign wrOk = WrEn && !Busy && (32'(WrAddr) < DEPTH);

`ifdef REG_FILE_PARITY_EN
    assign wrEntry = {evenPar(parMaxWidth'(WrData)) ^ ParInj, WrData};
`else
    assign wrEntry = WrData;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        unique case (state)
            IDLE: begin
                if (ClrReq) begin
                    stateNext = CLEAR;
                    cntNext   = '0;
                end
            end
            CLEAR: begin
                cntNext = cnt + ADDR'(1);
                if (32'(cnt) == DEPTH - 1) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The clear walk owns the array while busy; user writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Busy) begin
            mem[cnt] <= '0;
        end else if (wrOk) begin
            mem[WrAddr] <= wrEntry;
        end
    end

    rf_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) uPort0 (
        .clk     (clk),
        .rst     (rst),
        .Busy    (Busy),
        .RdEn    (RdEn0),
        .RdAddr  (RdAddr0),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .Mem     (mem),
        .RdData  (RdData0),
        .RdValid (RdValid0)
`ifdef REG_FILE_PARITY_EN
        ,
        .RdErr   (RdErr0)
`endif
    );

    rf_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) uPort1 (
        .clk     (clk),
        .rst     (rst),
        .Busy    (Busy),
        .RdEn    (RdEn1),
        .RdAddr  (RdAddr1),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .Mem     (mem),
        .RdData  (RdData1),
        .RdValid (RdValid1)
`ifdef REG_FILE_PARITY_EN
        ,
        .RdErr   (RdErr1)
`endif
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench: DEPTH=8 and DEPTH=6 instances driven in lockstep.
// Parity checks are compiled in with REG_FILE_PARITY_EN.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        WrEn;
    logic [2:0]  WrAddr;
    logic [15:0] WrData;
    logic        RdEn0;
    logic [2:0]  RdAddr0;
    logic        RdEn1;
    logic [2:0]  RdAddr1;
    logic        ClrReq;
    logic [15:0] aD0, aD1, bD0, bD1;
    logic        aV0, aV1, bV0, bV1;
    logic        aBusy, bBusy;
`ifdef REG_FILE_PARITY_EN
    logic        ParInj;
    logic        aE0, aE1, bE0, bE1;
`endif

    typedef struct packed {
        logic [1:0]       b;
        logic [3:0]       e;
        logic [3:0]       v;
        logic [3:0][15:0] d;
    } exp_t;

    exp_t        sbq [$];
    exp_t        me;
    int          nVec = 0;
    int          nBad = 0;

    logic [15:0] mm [2][8];
    logic        mp [2][8];
    int          mCnt [2];
    logic [1:0]  mBusy;
    logic [15:0] mLast [4];

    logic [3:0][15:0] od;
    logic [3:0]       ov;
    logic [1:0]       ob;

    assign od = {bD1, bD0, aD1, aD0};
    assign ov = {bV1, bV0, aV1, aV0};
    assign ob = {bBusy, aBusy};

    always #5 clk = ~clk;

    reg_file_2r1w #(.WIDTH(16), .DEPTH(8)) dutA (
        .clk(clk), .rst(rst),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEn0(RdEn0), .RdAddr0(RdAddr0), .RdData0(aD0), .RdValid0(aV0),
        .RdEn1(RdEn1), .RdAddr1(RdAddr1), .RdData1(aD1), .RdValid1(aV1),
        .ClrReq(ClrReq), .Busy(aBusy)
`ifdef REG_FILE_PARITY_EN
        , .ParInj(ParInj), .RdErr0(aE0), .RdErr1(aE1)
`endif
    );

    reg_file_2r1w #(.WIDTH(16), .DEPTH(6)) dutB (
        .clk(clk), .rst(rst),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .RdEn0(RdEn0), .RdAddr0(RdAddr0), .RdData0(bD0), .RdValid0(bV0),
        .RdEn1(RdEn1), .RdAddr1(RdAddr1), .RdData1(bD1), .RdValid1(bV1),
        .ClrReq(ClrReq), .Busy(bBusy)
`ifdef REG_FILE_PARITY_EN
        , .ParInj(ParInj), .RdErr0(bE0), .RdErr1(bE1)
`endif
    );

    // Scoreboard: pop one expectation per stepped edge, compare 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            for (int i = 0; i < 4; i++) begin
                nVec++;
                if (ov[i] !== me.v[i]) begin
                    nBad++;
                    $display("FAIL valid[%0d] t=%0t got %b want %b", i, $time, ov[i], me.v[i]);
                end
                nVec++;
                if (od[i] !== me.d[i]) begin
                    nBad++;
                    $display("FAIL data[%0d] t=%0t got %h want %h", i, $time, od[i], me.d[i]);
                end
`ifdef REG_FILE_PARITY_EN
                nVec++;
                if ({bE1, bE0, aE1, aE0} !== me.e) begin
                    nBad++;
                    $display("FAIL rderr t=%0t got %b want %b", $time, {bE1, bE0, aE1, aE0}, me.e);
                end
`endif
            end
            for (int k = 0; k < 2; k++) begin
                nVec++;
                if (ob[k] !== me.b[k]) begin
                    nBad++;
                    $display("FAIL busy[%0d] t=%0t got %b want %b", k, $time, ob[k], me.b[k]);
                end
            end
        end
    end

    task automatic mdlReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                mm[k][i] = '0;
                mp[k][i] = 1'b0;
            end
            mCnt[k] = 0;
        end
        mBusy = '0;
        for (int i = 0; i < 4; i++) mLast[i] = '0;
    endtask

    task automatic step(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic r0, input logic [2:0] a0,
                        input logic r1, input logic [2:0] a1,
                        input logic clr, input logic inj);
        exp_t        e;
        int          dd;
        int          idx;
        logic        en;
        logic [2:0]  a;
        e = '0;
        WrEn = we; WrAddr = wa; WrData = wd;
        RdEn0 = r0; RdAddr0 = a0; RdEn1 = r1; RdAddr1 = a1;
        ClrReq = clr;
`ifdef REG_FILE_PARITY_EN
        ParInj = inj;
`endif
        for (int k = 0; k < 2; k++) begin
            dd = (k == 0) ? 8 : 6;
            for (int p = 0; p < 2; p++) begin
                idx = k * 2 + p;
                en  = (p == 1) ? r1 : r0;
                a   = (p == 1) ? a1 : a0;
                if (en && !mBusy[k]) begin
                    e.v[idx] = 1'b1;
                    if (a >= dd) begin
                        e.d[idx] = '0;
                    end else if (we && wa == a) begin
                        e.d[idx] = wd;
                    end else begin
                        e.d[idx] = mm[k][a];
                        e.e[idx] = (^mm[k][a]) != mp[k][a];
                    end
                    mLast[idx] = e.d[idx];
                end else begin
                    e.d[idx] = mLast[idx];
                end
            end
            if (mBusy[k]) begin
                mm[k][mCnt[k]] = '0;
                mp[k][mCnt[k]] = 1'b0;
                mCnt[k]++;
                if (mCnt[k] == dd) mBusy[k] = 1'b0;
            end else begin
                if (we && wa < dd) begin
                    mm[k][wa] = wd;
                    mp[k][wa] = (^wd) ^ inj;
                end
                if (clr) begin
                    mBusy[k] = 1'b1;
                    mCnt[k]  = 0;
                end
            end
            e.b[k] = mBusy[k];
        end
        sbq.push_back(e);
        @(posedge clk);
        #2;
        WrEn = 0; RdEn0 = 0; RdEn1 = 0; ClrReq = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        WrEn = 0; WrAddr = 0; WrData = 0;
        RdEn0 = 0; RdAddr0 = 0; RdEn1 = 0; RdAddr1 = 0; ClrReq = 0;
`ifdef REG_FILE_PARITY_EN
        ParInj = 0;
`endif
        mdlReset();
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            nVec++;
            if (od[i] !== 16'h0 || ov[i] !== 1'b0) begin
                nBad++;
                $display("FAIL reset_port[%0d] got d=%h v=%b want 0/0", i, od[i], ov[i]);
            end
        end
        nVec++;
        if (ob !== 2'b00) begin
            nBad++;
            $display("FAIL reset_busy got %b want 00", ob);
        end
        rst = 1'b0;
        step(0, 0, 0, 1, 0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 5, 1, 7, 0, 0);
    endtask

    task automatic test_basic();
        step(1, 3, 16'h000B, 0, 0, 0, 0, 0, 0);
        step(1, 7, 16'h0001, 0, 0, 0, 0, 0, 0);
        step(1, 1, 16'h001C, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 1, 1, 0, 0);
        step(0, 0, 0, 1, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_bypass();
        step(1, 5, 16'hBEEF, 1, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 2, 16'h1357, 1, 2, 1, 2, 0, 0);
        step(0, 0, 0, 1, 3, 1, 3, 0, 0);
    endtask

    task automatic test_clear();
        int busyCnt;
        for (int i = 0; i < 8; i++) step(1, 3'(i), 16'hA5A5, 0, 0, 0, 0, 0, 0);
        step(1, 4, 16'h7777, 1, 4, 1, 3, 1, 0);
        busyCnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (aBusy === 1'b1) busyCnt++;
            step(1, 2, 16'h1234, 1, 2, 1, 4, (i < 4) ? 1'b1 : 1'b0, 0);
        end
        nVec++;
        if (busyCnt !== 8 || aBusy !== 1'b0) begin
            nBad++;
            $display("FAIL clear_busy_len got %0d busy_after=%b want 8/0", busyCnt, aBusy);
        end
        for (int i = 0; i < 8; i += 2) step(0, 0, 0, 1, 3'(i), 1, 3'(i + 1), 0, 0);
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 8; i++) step(1, 3'(i), 16'h1111 * 16'(i + 1), 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 6, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        nVec++;
        if (ob !== 2'b00 || ov !== 4'b0000) begin
            nBad++;
            $display("FAIL async_abort got busy=%b valid=%b want 00/0000", ob, ov);
        end
        mdlReset();
        nVec++;
        if (od !== '0) begin
            nBad++;
            $display("FAIL async_data got %h want 0", od);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 8; i += 2) step(0, 0, 0, 1, 3'(i), 1, 3'(i + 1), 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 16'h4242, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic test_out_of_range();
        step(1, 5, 16'h5555, 0, 0, 0, 0, 0, 0);
        step(1, 6, 16'hDEAD, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 6, 1, 7, 0, 0);
        step(1, 7, 16'hCAFE, 1, 7, 1, 5, 0, 0);
        step(0, 0, 0, 1, 5, 1, 6, 0, 0);
    endtask

`ifdef REG_FILE_PARITY_EN
    task automatic test_parity();
        step(1, 4, 16'h0003, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 4, 1, 4, 0, 0);
        step(1, 4, 16'h0003, 1, 4, 0, 0, 0, 1);
        step(1, 4, 16'h0003, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 4, 0, 0, 0, 0);
        step(1, 6, 16'h0001, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 6, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_out_of_range();
`ifdef REG_FILE_PARITY_EN
        test_parity();
`endif
        test_random();
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
